mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single 32-bit memory port between the pipeline's instruction-fetch stage and its data (load/store) stage. It sits between the MIPS32 core and the memory interface. It latches one transaction at a time and drives the memory strobes. It returns a one-cycle ready pulse to the winning requester and alternates grants when both requesters contend, so neither stage starves.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mem_arb_watchdog.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the memory-port arbiter.
//   arb_state_t      - arbiter FSM states
//   arb_grant_t      - which requester was granted most recently
//   MEM_TIMEOUT_DATA - read data returned on a watchdog-forced completion
package mips_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_BUSY = 2'd1,
        ARB_D_BUSY  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } arb_grant_t;

    localparam logic [31:0] MEM_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: wait-cycle counter and sticky timeout flag for mem_port_arbiter.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   busy       - arbiter holds a granted transaction this cycle
//   grant      - a new transaction is granted at the coming edge (clears the count)
//   mem_ready  - memory completion
//   expire     - force completion this cycle (combinational)
//   timeout    - sticky error flag, cleared only by reset
module mem_arb_watchdog
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic grant,
    input  logic mem_ready,
    output logic expire,
    output logic timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;
    logic            waiting;

    assign waiting = busy && !mem_ready;

    // cnt_q counts completed wait cycles, so the wait cycle that brings the
    // total to TIMEOUT is the one seen with cnt_q == TIMEOUT-1.
    assign expire  = waiting && (cnt_q == CntW'(TIMEOUT - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (grant) begin
                cnt_q <= '0;
            end else if (waiting && !expire) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 32-bit memory port between instruction fetch (if_*)
// and the load/store stage (d_*). One transaction in flight; alternates grants
// under contention; a mandatory IDLE cycle follows every completion.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   if_req/if_addr                  - fetch request, held until if_ready
//   if_ready/if_rdata               - fetch completion pulse and data (0 otherwise)
//   d_read/d_write/d_addr/d_wdata/d_be - data request, held until d_ready
//   d_ready/d_rdata                 - data completion pulse and load data (0 otherwise)
//   mem_addr/mem_wdata/mem_we/mem_re - registered memory strobes
//   mem_ready/mem_rdata             - memory completion and read data
//   mem_timeout                     - sticky watchdog flag
// Build option: define MEM_ARB_WATCHDOG_EN to force completion after TIMEOUT
// wait cycles; without it mem_timeout is tied 0 and BUSY waits indefinitely.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_we,
    output logic              mem_re,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              mem_timeout
);

    arb_state_t        state_q, state_d;
    arb_grant_t        last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        we_q;
    logic              re_q;

    logic        d_req;
    logic        busy;
    logic        grant;
    logic        expire;
    logic        done;
    logic [31:0] rsp_data;

    assign d_req = d_read | d_write;
    assign busy  = (state_q != ARB_IDLE);

`ifdef MEM_ARB_WATCHDOG_EN
    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .grant    (grant),
        .mem_ready(mem_ready),
        .expire   (expire),
        .timeout  (mem_timeout)
    );
`else
    // TIMEOUT has no role without the watchdog.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b0;
    assign mem_timeout    = 1'b0;
`endif

    // mem_ready is only meaningful while a transaction is held.
    assign done = busy && (mem_ready || expire);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                // On contention the requester not granted last wins.
                if (d_req && (!if_req || last_grant_q == GRANT_IF)) begin
                    state_d      = ARB_D_BUSY;
                    last_grant_d = GRANT_D;
                end else if (if_req) begin
                    state_d      = ARB_IF_BUSY;
                    last_grant_d = GRANT_IF;
                end
            end
            ARB_IF_BUSY, ARB_D_BUSY: begin
                if (done) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= '0;
            re_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (grant) begin
                if (state_d == ARB_D_BUSY) begin
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    // A simultaneous read and write is treated as a write.
                    we_q    <= d_write ? d_be : 4'b0000;
                    re_q    <= !d_write;
                end else begin
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                    we_q    <= 4'b0000;
                    re_q    <= 1'b1;
                end
            end else if (done) begin
                we_q <= 4'b0000;
                re_q <= 1'b0;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;

    assign if_ready = (state_q == ARB_IF_BUSY) && done;
    assign d_ready  = (state_q == ARB_D_BUSY) && done;

    assign rsp_data = expire ? MEM_TIMEOUT_DATA : mem_rdata;

    assign if_rdata = if_ready ? rsp_data : 32'h0;
    // Stores return no data unless the watchdog forced the completion.
    assign d_rdata  = (d_ready && (re_q || expire)) ? rsp_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mips_pkg::*;

    localparam int unsigned ADDR_W  = 30;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ready;
    logic [31:0]       if_rdata;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic [3:0]        d_be = '0;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_we;
    logic              mem_re;
    logic              mem_ready = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              mem_timeout;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ready   (if_ready),
        .if_rdata   (if_rdata),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_timeout(mem_timeout)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: random wait states, or values scripted by the main sequence.
    bit          rand_mem = 1'b0;
    logic        fixed_ready = 1'b0;
    logic [31:0] fixed_rdata = '0;

    always @(posedge clk) begin
        #2;
        if (rand_mem) begin
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
        end else begin
            mem_ready = fixed_ready;
            mem_rdata = fixed_rdata;
        end
    end

    // Reference model: transaction-level view of the shared port.
    typedef enum int {OWN_NONE, OWN_IF, OWN_D} own_e;
    typedef struct {
        bit                active;
        bit                store;
        logic              re;
        logic [3:0]        we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        bit                tmo;
    } strobe_t;
    typedef struct {
        own_e        who;
        logic [31:0] rdata;
    } cpl_t;

    strobe_t strobe_q[$];
    cpl_t    cpl_q[$];
    own_e    owner    = OWN_NONE;
    bit      prefer_d = 1'b1;
    strobe_t txn;
    int      waits    = 0;
    bit      tmo_seen = 1'b0;
    bit      checking = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            strobe_t     s;
            cpl_t        c;
            own_e        win;
            bit          done;
            logic [31:0] rd;
            s        = txn;
            s.active = (owner != OWN_NONE);
            if (!s.active) begin
                s.re = 1'b0;
                s.we = 4'b0000;
            end
            s.tmo = tmo_seen;
            strobe_q.push_back(s);

            done = 1'b0;
            rd   = '0;
            if (owner != OWN_NONE) begin
                if (mem_ready) begin
                    done = 1'b1;
                    rd   = txn.store ? 32'h0 : mem_rdata;
                end
`ifdef MEM_ARB_WATCHDOG_EN
                else begin
                    waits++;
                    if (waits == TIMEOUT) begin
                        done     = 1'b1;
                        rd       = MEM_TIMEOUT_DATA;
                        tmo_seen = 1'b1;
                    end
                end
`endif
            end

            if (done) begin
                c.who   = owner;
                c.rdata = rd;
                cpl_q.push_back(c);
                owner = OWN_NONE;
            end else if (owner == OWN_NONE) begin
                win = OWN_NONE;
                if ((d_read || d_write) && if_req) win = prefer_d ? OWN_D : OWN_IF;
                else if (d_read || d_write)        win = OWN_D;
                else if (if_req)                   win = OWN_IF;
                if (win == OWN_D) begin
                    txn.store = d_write;
                    txn.addr  = d_addr;
                    txn.wdata = d_wdata;
                    txn.we    = d_write ? d_be : 4'b0000;
                    txn.re    = !d_write;
                end else if (win == OWN_IF) begin
                    txn.store = 1'b0;
                    txn.addr  = if_addr;
                    txn.wdata = '0;
                    txn.we    = 4'b0000;
                    txn.re    = 1'b1;
                end
                if (win != OWN_NONE) begin
                    prefer_d = (win == OWN_IF);
                    waits    = 0;
                    owner    = win;
                end
            end

            if (reset) begin
                owner    = OWN_NONE;
                prefer_d = 1'b1;
                tmo_seen = 1'b0;
            end
        end
    end

    // Monitor: compares DUT strobes every cycle and pops expected completions.
    always @(negedge clk) begin
        #2;
        if (checking && strobe_q.size() != 0) begin
            strobe_t     s;
            cpl_t        c;
            logic [1:0]  exp_rdy;
            logic [31:0] exp_if;
            logic [31:0] exp_d;
            s = strobe_q.pop_front();
            check("mem_re", mem_re, s.re);
            check("mem_we", mem_we, s.we);
            check("mem_timeout", mem_timeout, s.tmo);
            if (s.active) check("mem_addr", mem_addr, s.addr);
            if (s.active && s.we != 4'b0000) check("mem_wdata", mem_wdata, s.wdata);
            exp_rdy = 2'b00;
            exp_if  = '0;
            exp_d   = '0;
            if (cpl_q.size() != 0) begin
                c = cpl_q.pop_front();
                if (c.who == OWN_IF) begin
                    exp_rdy = 2'b10;
                    exp_if  = c.rdata;
                end else begin
                    exp_rdy = 2'b01;
                    exp_d   = c.rdata;
                end
            end
            check("ready_if_d", {if_ready, d_ready}, exp_rdy);
            check("if_rdata", if_rdata, exp_if);
            check("d_rdata", d_rdata, exp_d);
        end
    end

    task automatic do_reset();
        fixed_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic fetch_driver();
        int unsigned gap;
        int          cyc;
        bit          ok;
        for (int t = 0; t < 80; t++) begin
            gap    = $urandom_range(0, 3);
            if_req = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            if_req  = 1'b1;
            if_addr = ADDR_W'($urandom);
            ok  = 1'b0;
            cyc = 0;
            while (!ok && cyc < 200) begin
                @(negedge clk);
                #3;
                cyc++;
                ok = if_ready;
                @(posedge clk);
                #1;
            end
            check("fetch_handshake", ok, 1);
        end
        if_req = 1'b0;
    endtask

    task automatic data_driver();
        int unsigned gap;
        int unsigned op;
        int          cyc;
        bit          ok;
        for (int t = 0; t < 80; t++) begin
            gap     = $urandom_range(0, 3);
            d_read  = 1'b0;
            d_write = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            op      = $urandom_range(0, 3);
            d_read  = (op != 2);
            d_write = (op >= 2);
            d_addr  = ADDR_W'($urandom);
            d_wdata = $urandom;
            d_be    = 4'($urandom);
            ok  = 1'b0;
            cyc = 0;
            while (!ok && cyc < 200) begin
                @(negedge clk);
                #3;
                cyc++;
                ok = d_ready;
                @(posedge clk);
                #1;
            end
            check("data_handshake", ok, 1);
        end
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    int          cnt_re, cnt_rdy, cnt_we, cyc, n, last_c;
    bit          seen;
    logic [31:0] got_rdata;
    logic [1:0]  exp_pair;

    initial begin
        repeat (2) @(posedge clk);
        #1 checking = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_d_ready", d_ready, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_timeout", mem_timeout, 0);
        reset = 1'b0;

        // Fetch only, memory ready in the first busy cycle.
        fixed_rdata = 32'h8C220004;
        fixed_ready = 1'b1;
        if_req      = 1'b1;
        if_addr     = 'h100;
        cnt_re      = 0;
        cnt_rdy     = 0;
        got_rdata   = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #3;
            if (mem_re) cnt_re++;
            if (if_ready) begin
                cnt_rdy++;
                got_rdata = if_rdata;
            end
            @(posedge clk);
            #1;
            if (cnt_rdy != 0) if_req = 1'b0;
        end
        check("fetch_re_cycles", cnt_re, 1);
        check("fetch_ready_pulses", cnt_rdy, 1);
        check("fetch_rdata", got_rdata, 32'h8C220004);

        // Contention from reset: data first, then alternate with one bubble.
        do_reset();
        fixed_ready = 1'b1;
        if_req  = 1'b1;
        if_addr = 'h200;
        d_read  = 1'b1;
        d_addr  = 'h300;
        n       = 0;
        cyc     = 0;
        last_c  = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            #3;
            cyc++;
            if (if_ready || d_ready) begin
                exp_pair = (n % 2 == 0) ? 2'b01 : 2'b10;
                check("contention_order", {if_ready, d_ready}, exp_pair);
                if (n > 0) check("contention_gap", cyc - last_c, 2);
                last_c = cyc;
                n++;
            end
            @(posedge clk);
            #1;
        end
        check("contention_grants", n, 4);
        if_req = 1'b0;
        d_read = 1'b0;

        // Store with three wait states.
        fixed_ready = 1'b0;
        fixed_rdata = 32'hCAFEF00D;
        d_write = 1'b1;
        d_be    = 4'b0011;
        d_wdata = 32'h12345678;
        d_addr  = 'h40;
        cnt_we  = 0;
        cnt_rdy = 0;
        cyc     = 0;
        got_rdata = 32'hFFFFFFFF;
        while (cnt_rdy == 0 && cyc < 20) begin
            @(negedge clk);
            #3;
            cyc++;
            if (mem_we == 4'b0011) cnt_we++;
            if (d_ready) begin
                cnt_rdy++;
                got_rdata = d_rdata;
            end
            if (cnt_we == 3) fixed_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        d_write     = 1'b0;
        fixed_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #3;
            if (d_ready) cnt_rdy++;
            if (mem_we == 4'b0011) cnt_we++;
            @(posedge clk);
            #1;
        end
        check("store_we_cycles", cnt_we, 4);
        check("store_ready_pulses", cnt_rdy, 1);
        check("store_d_rdata", got_rdata, 0);

        // Reset while a load is in flight.
        d_read = 1'b1;
        d_addr = 'h50;
        seen   = 1'b0;
        cyc    = 0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            #3;
            cyc++;
            if (mem_re) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("reset_mid_busy_reached", seen, 1);
        reset   = 1'b1;
        d_read  = 1'b0;
        cnt_rdy = 0;
        @(negedge clk);
        #3;
        if (d_ready) cnt_rdy++;
        @(posedge clk);
        #1;
        @(negedge clk);
        #3;
        check("reset_mid_re", mem_re, 0);
        check("reset_mid_we", mem_we, 0);
        if (d_ready) cnt_rdy++;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #3;
            if (d_ready) cnt_rdy++;
            @(posedge clk);
            #1;
        end
        check("reset_mid_no_ready", cnt_rdy, 0);

        // Randomized traffic from both requesters.
        rand_mem = 1'b1;
        fork
            fetch_driver();
            data_driver();
        join
        rand_mem    = 1'b0;
        fixed_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // Memory never answers.
        if_req  = 1'b1;
        if_addr = 'h3F0;
`ifdef MEM_ARB_WATCHDOG_EN
        begin
            int busy_cyc;
            busy_cyc  = 0;
            seen      = 1'b0;
            cyc       = 0;
            got_rdata = '0;
            while (!seen && cyc < 4 * TIMEOUT + 10) begin
                @(negedge clk);
                #3;
                cyc++;
                if (mem_re) busy_cyc++;
                if (if_ready) begin
                    seen      = 1'b1;
                    got_rdata = if_rdata;
                end
                @(posedge clk);
                #1;
            end
            if_req = 1'b0;
            check("wd_ready", seen, 1);
            check("wd_wait_cycle", busy_cyc, TIMEOUT);
            check("wd_rdata", got_rdata, 32'hDEADBEEF);
            repeat (5) begin
                @(negedge clk);
                #3;
                check("wd_sticky", mem_timeout, 1);
                @(posedge clk);
                #1;
            end
        end
`else
        cnt_rdy = 0;
        repeat (1000) begin
            @(negedge clk);
            #3;
            if (if_ready) cnt_rdy++;
            @(posedge clk);
            #1;
        end
        check("hang_no_ready", cnt_rdy, 0);
        check("hang_timeout_flag", mem_timeout, 0);
        if_req = 1'b0;
`endif
        do_reset();
        @(negedge clk);
        #3;
        check("final_timeout_cleared", mem_timeout, 0);
        check("final_re", mem_re, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: got no summary by %0t, required run to finish", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
